tmds_serial_ctrl: RTL and testbench

Parametrised control FSM for the TMDS output serializer. It replaces the fixed 3-state output controller. It handshakes parallel symbols in from the encoder and drives load and shift strobes for CHANNELS shift registers, with a per-channel enable mask. A bit counter sequences SYMBOL_BITS shifts per symbol, and the block detects and counts underruns in continuous (video-active) mode.

---
 rtl/tmds_serial_ctrl.sv | 110 +++++++++++
 tb/tb_tmds_serial_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_serial_ctrl.sv
// Output controller for the TMDS serializer. It takes parallel symbols from the encoder
// and sequences load/shift strobes for CHANNELS lanes. It also flags and counts underruns.
module tmds_serial_ctrl #(
    parameter int SYMBOL_BITS = 10,
    parameter int CHANNELS    = 3,
    parameter int CONTINUOUS  = 1,
    parameter int CNT_BITS    = 8,
    localparam int IDX_BITS   = $clog2(SYMBOL_BITS)
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                enable,
    input  logic                data_ready,
    input  logic [CHANNELS-1:0] channel_mask,
    input  logic                clr_count,
    output logic                data_ack,
    output logic                load_enable,
    output logic [CHANNELS-1:0] shift_enable,
    output logic [IDX_BITS-1:0] bit_index,
    output logic                symbol_done,
    output logic                busy,
    output logic                underrun,
    output logic [CNT_BITS-1:0] underrun_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(SYMBOL_BITS - 1);

    state_t              state_q, state_d;
    logic [IDX_BITS-1:0] bit_cnt_q, bit_cnt_d;
    logic [CHANNELS-1:0] mask_q, mask_d;
    logic [CNT_BITS-1:0] count_q, count_d;

    logic startReq;
    logic lastShift;

    assign startReq  = enable && data_ready;
    assign lastShift = (state_q == SHIFT) && (bit_cnt_q == LAST_IDX);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            mask_q    <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            mask_q    <= mask_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d   = IDLE;
        bit_cnt_d = bit_cnt_q;
        mask_d    = mask_q;
        case (state_q)
            IDLE: begin
                state_d = startReq ? LOAD : IDLE;
            end
            LOAD: begin
                state_d   = SHIFT;
                mask_d    = channel_mask;
                bit_cnt_d = '0;
            end
            SHIFT: begin
                if (lastShift) begin
                    state_d   = startReq ? LOAD : IDLE;
                    bit_cnt_d = '0;
                end else begin
                    state_d   = SHIFT;
                    bit_cnt_d = bit_cnt_q + IDX_BITS'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

    // A gap after the last shift only counts as an underrun while the link is enabled.
    always_comb begin
        load_enable  = (state_q == LOAD);
        data_ack     = (state_q == LOAD);
        busy         = (state_q == LOAD) || (state_q == SHIFT);
        shift_enable = (state_q == SHIFT) ? mask_q : '0;
        bit_index    = (state_q == SHIFT) ? bit_cnt_q : '0;
        symbol_done  = lastShift;
        underrun     = lastShift && (CONTINUOUS != 0) && enable && !data_ready;
    end

    always_comb begin
        count_d = count_q;
        if (clr_count) begin
            count_d = '0;
        end else if (underrun && (count_q != {CNT_BITS{1'b1}})) begin
            count_d = count_q + CNT_BITS'(1);
        end
    end

    assign underrun_count = count_q;

endmodule

// File: tb/tb_tmds_serial_ctrl.sv
// Directed bench for tmds_serial_ctrl. One instance is continuous with a 2-bit counter.
// A second instance is non-continuous. Inputs change and outputs are sampled on falling edges.
module tb_tmds_serial_ctrl;

    logic       clk = 1'b0;
    logic       n_rst = 1'b1;
    logic       enable = 1'b0;
    logic       dataReady = 1'b0;
    logic [2:0] channelMask = 3'b000;
    logic       clrCount = 1'b0;

    logic       d0Ack, d0Load, d0Done, d0Busy, d0Under;
    logic [2:0] d0Shift;
    logic [3:0] d0Idx;
    logic [1:0] d0Count;

    logic       d1Ack, d1Load, d1Done, d1Busy, d1Under;
    logic [2:0] d1Shift;
    logic [3:0] d1Idx;
    logic [7:0] d1Count;

    logic [11:0] d0Vec, d1Vec;

    int checks = 0;
    int failures = 0;

    assign d0Vec = {d0Load, d0Ack, d0Shift, d0Idx, d0Done, d0Busy, d0Under};
    assign d1Vec = {d1Load, d1Ack, d1Shift, d1Idx, d1Done, d1Busy, d1Under};

    always #5 clk = ~clk;

    tmds_serial_ctrl #(.SYMBOL_BITS(10), .CHANNELS(3), .CONTINUOUS(1), .CNT_BITS(2)) dut0 (
        .clk(clk), .n_rst(n_rst), .enable(enable), .data_ready(dataReady),
        .channel_mask(channelMask), .clr_count(clrCount),
        .data_ack(d0Ack), .load_enable(d0Load), .shift_enable(d0Shift),
        .bit_index(d0Idx), .symbol_done(d0Done), .busy(d0Busy),
        .underrun(d0Under), .underrun_count(d0Count)
    );

    tmds_serial_ctrl #(.SYMBOL_BITS(10), .CHANNELS(3), .CONTINUOUS(0), .CNT_BITS(8)) dut1 (
        .clk(clk), .n_rst(n_rst), .enable(enable), .data_ready(dataReady),
        .channel_mask(channelMask), .clr_count(clrCount),
        .data_ack(d1Ack), .load_enable(d1Load), .shift_enable(d1Shift),
        .bit_index(d1Idx), .symbol_done(d1Done), .busy(d1Busy),
        .underrun(d1Under), .underrun_count(d1Count)
    );

    task automatic do_reset();
        n_rst = 1'b0;
        enable = 1'b0;
        dataReady = 1'b0;
        clrCount = 1'b0;
        channelMask = 3'b000;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic test_reset();
        #2 n_rst = 1'b0;
        #1;
        checks++;
        if (d0Vec !== 12'h000 || d1Vec !== 12'h000) begin
            failures++;
            $display("[TB] FAIL reset_outputs got d0=%h d1=%h exp=000", d0Vec, d1Vec);
        end
        checks++;
        if (d0Count !== 2'd0 || d1Count !== 8'd0) begin
            failures++;
            $display("[TB] FAIL reset_count got d0=%0d d1=%0d exp=0", d0Count, d1Count);
        end
        do_reset();
    endtask

    task automatic test_single();
        logic [11:0] exp;
        logic [3:0]  idx;
        logic [2:0]  sh;
        do_reset();
        channelMask = 3'b101;
        enable = 1'b1;
        dataReady = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            sh  = (c >= 2 && c <= 11) ? 3'b101 : 3'b000;
            idx = (c >= 2 && c <= 11) ? 4'(c - 2) : 4'd0;
            exp = {c == 1, c == 1, sh, idx, c == 11, c <= 11, 1'b0};
            checks++;
            if (d1Vec !== exp) begin
                failures++;
                $display("[TB] FAIL single_c%0d got=%h exp=%h", c, d1Vec, exp);
            end
            if (c == 1) dataReady = 1'b0;
        end
        checks++;
        if (d1Count !== 8'd0) begin
            failures++;
            $display("[TB] FAIL single_count got=%0d exp=0", d1Count);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp;
        logic [3:0]  idx;
        logic [2:0]  sh;
        logic        ld, inSym;
        int          acks;
        acks = 0;
        do_reset();
        channelMask = 3'b111;
        enable = 1'b1;
        dataReady = 1'b1;
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            ld    = (c == 1) || (c == 12) || (c == 23);
            inSym = (c >= 2) && (c <= 33) && !ld;
            sh    = inSym ? 3'b111 : 3'b000;
            idx   = inSym ? 4'((c - 2) % 11) : 4'd0;
            exp   = {ld, ld, sh, idx, inSym && idx == 4'd9, c <= 33, c == 33};
            if (d0Ack === 1'b1) acks++;
            checks++;
            if (d0Vec !== exp) begin
                failures++;
                $display("[TB] FAIL b2b_c%0d got=%h exp=%h", c, d0Vec, exp);
            end
            if (c == 33) begin
                checks++;
                if (d0Count !== 2'd0 || d1Under !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL b2b_pre_count got cnt=%0d nc_under=%b exp cnt=0 nc_under=0", d0Count, d1Under);
                end
            end
            if (c == 34) begin
                checks++;
                if (d0Count !== 2'd1) begin
                    failures++;
                    $display("[TB] FAIL b2b_count got=%0d exp=1", d0Count);
                end
            end
            if (c == 23) dataReady = 1'b0;
        end
        checks++;
        if (acks != 3) begin
            failures++;
            $display("[TB] FAIL b2b_acks got=%0d exp=3", acks);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        channelMask = 3'b011;
        enable = 1'b1;
        dataReady = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c == 1 || c == 13) dataReady = 1'b0;
            if (c == 12) begin
                checks++;
                if (d0Count !== 2'd1) begin
                    failures++;
                    $display("[TB] FAIL rstmid_precount got=%0d exp=1", d0Count);
                end
                dataReady = 1'b1;
            end
        end
        checks++;
        if (d0Idx !== 4'd4 || d0Shift !== 3'b011) begin
            failures++;
            $display("[TB] FAIL rstmid_position got idx=%0d sh=%b exp idx=4 sh=011", d0Idx, d0Shift);
        end
        #2 n_rst = 1'b0;
        #1;
        checks++;
        if (d0Vec !== 12'h000 || d0Count !== 2'd0) begin
            failures++;
            $display("[TB] FAIL rstmid_async got vec=%h cnt=%0d exp vec=000 cnt=0", d0Vec, d0Count);
        end
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        checks++;
        if (d0Vec !== 12'h000 || d0Count !== 2'd0) begin
            failures++;
            $display("[TB] FAIL rstmid_idle got vec=%h cnt=%0d exp vec=000 cnt=0", d0Vec, d0Count);
        end
        dataReady = 1'b1;
        @(negedge clk);
        checks++;
        if (d0Vec !== {1'b1, 1'b1, 3'b000, 4'd0, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("[TB] FAIL rstmid_first_load got=%h exp=%h", d0Vec, 12'hC02);
        end
        dataReady = 1'b0;
    endtask

    task automatic test_enable_drop();
        logic [11:0] exp;
        logic [3:0]  idx;
        logic [2:0]  sh;
        do_reset();
        channelMask = 3'b111;
        enable = 1'b1;
        dataReady = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            sh  = (c >= 2 && c <= 11) ? 3'b111 : 3'b000;
            idx = (c >= 2 && c <= 11) ? 4'(c - 2) : 4'd0;
            exp = {c == 1, c == 1, sh, idx, c == 11, c <= 11, 1'b0};
            checks++;
            if (d0Vec !== exp) begin
                failures++;
                $display("[TB] FAIL endrop_c%0d got=%h exp=%h", c, d0Vec, exp);
            end
            if (c == 5) enable = 1'b0;
        end
        checks++;
        if (d0Count !== 2'd0) begin
            failures++;
            $display("[TB] FAIL endrop_count got=%0d exp=0", d0Count);
        end
        dataReady = 1'b0;
    endtask

    task automatic test_mask_change();
        logic [11:0] exp;
        logic [3:0]  idx;
        logic [2:0]  sh;
        do_reset();
        channelMask = 3'b111;
        enable = 1'b1;
        dataReady = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 11) begin
                sh = 3'b111; idx = 4'(c - 2);
            end else if (c >= 13 && c <= 22) begin
                sh = 3'b001; idx = 4'(c - 13);
            end else begin
                sh = 3'b000; idx = 4'd0;
            end
            exp = {c == 1 || c == 12, c == 1 || c == 12, sh, idx, c == 11 || c == 22, c <= 22, 1'b0};
            checks++;
            if (d0Vec !== exp) begin
                failures++;
                $display("[TB] FAIL mask_c%0d got=%h exp=%h", c, d0Vec, exp);
            end
            if (c == 5) channelMask = 3'b001;
            if (c == 12) enable = 1'b0;
        end
        dataReady = 1'b0;
    endtask

    task automatic test_saturation();
        logic [1:0] expCnt;
        do_reset();
        channelMask = 3'b001;
        enable = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            dataReady = 1'b1;
            @(negedge clk);
            dataReady = 1'b0;
            repeat (10) @(negedge clk);
            checks++;
            if (d0Under !== 1'b1 || d0Done !== 1'b1) begin
                failures++;
                $display("[TB] FAIL sat_pulse_n%0d got under=%b done=%b exp 1 1", n, d0Under, d0Done);
            end
            if (n == 6) clrCount = 1'b1;
            @(negedge clk);
            clrCount = 1'b0;
            if (n <= 5) expCnt = (n >= 3) ? 2'd3 : 2'(n);
            else if (n == 6) expCnt = 2'd0;
            else expCnt = 2'd1;
            checks++;
            if (d0Count !== expCnt) begin
                failures++;
                $display("[TB] FAIL sat_count_n%0d got=%0d exp=%0d", n, d0Count, expCnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_mid();
        test_enable_drop();
        test_mask_change();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
